i2c_cmd_sequencer: RTL and testbench
====================================

I2C_CMD_SEQUENCER -- requirements
Module: i2c_cmd_sequencer

Interface
REQ-001 Parameter DEPTH, 4, command FIFO depth in entries; power of two, minimum 2.
REQ-002 Parameter GAP_TICKS, 27, idle clk_i cycles required between the end of one transaction and the next execute.
REQ-003 Parameter BUSY_TIMEOUT, 8, maximum cycles allowed from execute to ctl_busy_i going high.
REQ-004 clk_i  in  1  single clock; all logic on its rising edge.
REQ-005 rst_i  in  1  reset; synchronous, active-high.
REQ-006 cmd_valid_i  in  1  command offered.
REQ-007 cmd_ready_o  out  1  command FIFO can accept.
REQ-008 cmd_addr_i  in  7  target address. cmd_rw_i  in  1  1=read, 0=write. cmd_reg_i  in  8  register. cmd_data_i  in  8  write data.
REQ-009 rsp_valid_o  out  1  read result available. rsp_ready_i  in  1  result consumed. rsp_data_o  out  8  read data. rsp_reg_o  out  8  register that was read.
REQ-010 ctl_address_o  out  7; ctl_rw_o  out  1; ctl_register_o  out  8; ctl_data_o  out  8: transaction fields to the downstream I2C controller.
REQ-011 ctl_execute_o  out  1  start pulse to controller. ctl_busy_i  in  1  controller busy. ctl_data_i  in  8  controller read data.
REQ-012 idle_o  out  1  FIFO empty and FSM in IDLE. err_o  out  1  sticky busy-timeout flag.

Function
REQ-013 Command FIFO SHALL store {addr,rw,reg,data} (24 bits), in order; push when cmd_valid_i && cmd_ready_o.
REQ-014 cmd_ready_o SHALL equal "count < DEPTH", independent of same-cycle pops; no push accepted when full.
REQ-015 Pointers SHALL wrap modulo DEPTH; count SHALL be ceil(log2(DEPTH))+1 bits, never exceeding DEPTH.
REQ-016 FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESPOND, GAP.
REQ-017 IDLE: if count != 0 and ctl_busy_i == 0, pop head, load ctl_* outputs from it, go ISSUE; otherwise stay.
REQ-018 ISSUE: ctl_execute_o SHALL be 1 for exactly this one cycle, starting one cycle after the popping edge; go WAIT_BUSY.
REQ-019 ctl_address_o/rw/register/data SHALL hold stable from ISSUE until the FSM next leaves GAP.
REQ-020 WAIT_BUSY: on ctl_busy_i == 1 go WAIT_DONE; if BUSY_TIMEOUT cycles elapse without it, set err_o, drop the command, go GAP.
REQ-021 WAIT_DONE: on ctl_busy_i == 0, capture ctl_data_i; go RESPOND if ctl_rw_o == 1, else GAP.
REQ-022 RESPOND: rsp_valid_o = 1 with rsp_data_o = captured data and rsp_reg_o = ctl_register_o; hold all three stable until rsp_ready_i == 1 is sampled, then deassert rsp_valid_o next cycle and go GAP.
REQ-023 GAP: count GAP_TICKS cycles, then go IDLE; GAP_TICKS = 0 SHALL go IDLE after one cycle.
REQ-024 No second execute SHALL occur while rsp_valid_o == 1 or in GAP.
REQ-025 FIFO pushes SHALL continue to be accepted in every FSM state.
REQ-026 err_o SHALL stay 1 until rst_i; a timeout SHALL NOT block later commands.
REQ-027 idle_o SHALL be 1 only when state == IDLE and count == 0.

Reset
REQ-028 While rst_i is sampled high: FSM -> IDLE, FIFO emptied, ctl_execute_o = 0, rsp_valid_o = 0, err_o = 0, ctl_* fields = 0, rsp_data_o = rsp_reg_o = 0, GAP and timeout counters = 0.
REQ-029 Reset mid-transaction SHALL discard the in-flight command and all queued commands; no response is produced for them.
REQ-030 After reset, no execute SHALL issue until ctl_busy_i is sampled low, per REQ-017.

Verification
REQ-031 Push write {0x40,0,0x06,0x55}; controller model busy for 100 cycles -> one execute pulse with ctl_* = 0x40/0/0x06/0x55, no rsp_valid_o, idle_o = 1 after GAP_TICKS.
REQ-032 Push read {0x40,1,0xFE}; model returns 0xA5; hold rsp_ready_i low 10 cycles -> rsp_valid_o held with rsp_data_o = 0xA5, rsp_reg_o = 0xFE, and no further execute during the hold.
REQ-033 Stall the model busy; offer DEPTH+1 commands -> DEPTH accepted, cmd_ready_o = 0 on the last; after release, all DEPTH commands issue in push order.
REQ-034 Two back-to-back writes -> second execute occurs no sooner than GAP_TICKS+1 cycles after ctl_busy_i falls.
REQ-035 Model never asserts busy -> err_o = 1 after BUSY_TIMEOUT cycles; the next queued command still issues and err_o stays 1.
REQ-036 Assert rst_i during WAIT_DONE with busy high and 2 entries queued -> all outputs at reset values next cycle, FIFO empty, no execute until busy is low.

Source files
------------

// File: rtl/i2c_cmd_sequencer.sv
// Queues I2C register transactions and hands them one at a time to a downstream
// controller, spacing them by an idle gap and returning read data on a response port.
module i2c_cmd_sequencer #(
  parameter int DEPTH        = 4,
  parameter int GAP_TICKS    = 27,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [6:0] cmd_addr_i,
  input  logic       cmd_rw_i,
  input  logic [7:0] cmd_reg_i,
  input  logic [7:0] cmd_data_i,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic [7:0] rsp_data_o,
  output logic [7:0] rsp_reg_o,
  output logic [6:0] ctl_address_o,
  output logic       ctl_rw_o,
  output logic [7:0] ctl_register_o,
  output logic [7:0] ctl_data_o,
  output logic       ctl_execute_o,
  input  logic       ctl_busy_i,
  input  logic [7:0] ctl_data_i,
  output logic       idle_o,
  output logic       err_o
);

  localparam int AW       = $clog2(DEPTH);
  localparam int CW       = AW + 1;
  localparam int GAP_LAST = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;
  localparam int GW       = (GAP_LAST > 0) ? $clog2(GAP_LAST + 1) : 1;
  localparam int TMO_LAST = (BUSY_TIMEOUT > 0) ? BUSY_TIMEOUT - 1 : 0;
  localparam int TW       = (TMO_LAST > 0) ? $clog2(TMO_LAST + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_RESPOND, S_GAP
  } state_t;

  typedef struct packed {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] rg;
    logic [7:0] data;
  } cmd_t;

  state_t          state_q, state_d;
  cmd_t            mem_q [DEPTH];
  cmd_t            cmd_in;
  cmd_t            ctl_q, ctl_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      rsp_data_q, rsp_data_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            err_q, err_d;
  logic            push, pop;

  assign cmd_in      = {cmd_addr_i, cmd_rw_i, cmd_reg_i, cmd_data_i};
  assign cmd_ready_o = count_q < CW'(DEPTH);
  assign push        = cmd_valid_i && cmd_ready_o;

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d    = state_q;
    ctl_d      = ctl_q;
    rsp_data_d = rsp_data_q;
    err_d      = err_q;
    gap_d      = '0;
    tmo_d      = '0;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0 && !ctl_busy_i) begin
          pop     = 1'b1;
          ctl_d   = mem_q[rd_ptr_q];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (ctl_busy_i) begin
          state_d = S_WAIT_DONE;
        end else if (tmo_q == TW'(TMO_LAST)) begin
          // The controller never acknowledged: flag it and abandon this command.
          err_d   = 1'b1;
          state_d = S_GAP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!ctl_busy_i) begin
          if (ctl_q.rw) begin
            rsp_data_d = ctl_data_i;
            state_d    = S_RESPOND;
          end else begin
            state_d = S_GAP;
          end
        end
      end
      S_RESPOND: if (rsp_ready_i) state_d = S_GAP;
      S_GAP: begin
        if (gap_q == GW'(GAP_LAST)) state_d = S_IDLE;
        else                        gap_d   = gap_q + GW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      ctl_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rsp_data_q <= '0;
      gap_q      <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctl_q      <= ctl_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rsp_data_q <= rsp_data_d;
      gap_q      <= gap_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
    end
  end

  // NOTE: storage is not reset; clearing the pointers and count empties the
  // FIFO, and stale entries are never read before being overwritten.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= cmd_in;
  end

  assign ctl_address_o  = ctl_q.addr;
  assign ctl_rw_o       = ctl_q.rw;
  assign ctl_register_o = ctl_q.rg;
  assign ctl_data_o     = ctl_q.data;
  assign ctl_execute_o  = (state_q == S_ISSUE);
  assign rsp_valid_o    = (state_q == S_RESPOND);
  assign rsp_data_o     = rsp_data_q;
  assign rsp_reg_o      = ctl_q.rg;
  assign idle_o         = (state_q == S_IDLE) && (count_q == '0);
  assign err_o          = err_q;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed-plus-random bench for i2c_cmd_sequencer with a behavioural controller
// model and an in-order command/response reference queue.
module tb_i2c_cmd_sequencer;

  localparam int DEPTH        = 4;
  localparam int GAP_TICKS    = 27;
  localparam int BUSY_TIMEOUT = 8;

  typedef struct packed {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] rg;
    logic [7:0] data;
  } cmd_t;

  typedef struct {
    cmd_t c;
    int   cyc;
    int   fall;
  } exec_t;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       cmd_valid_i, cmd_ready_o, cmd_rw_i;
  logic [6:0] cmd_addr_i;
  logic [7:0] cmd_reg_i, cmd_data_i;
  logic       rsp_valid_o, rsp_ready_i;
  logic [7:0] rsp_data_o, rsp_reg_o;
  logic [6:0] ctl_address_o;
  logic       ctl_rw_o, ctl_execute_o, ctl_busy_i;
  logic [7:0] ctl_register_o, ctl_data_o, ctl_data_i;
  logic       idle_o, err_o;

  i2c_cmd_sequencer #(
    .DEPTH(DEPTH), .GAP_TICKS(GAP_TICKS), .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_addr_i(cmd_addr_i), .cmd_rw_i(cmd_rw_i), .cmd_reg_i(cmd_reg_i), .cmd_data_i(cmd_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_reg_o(rsp_reg_o),
    .ctl_address_o(ctl_address_o), .ctl_rw_o(ctl_rw_o),
    .ctl_register_o(ctl_register_o), .ctl_data_o(ctl_data_o),
    .ctl_execute_o(ctl_execute_o), .ctl_busy_i(ctl_busy_i), .ctl_data_i(ctl_data_i),
    .idle_o(idle_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  // Controller model knobs and observations
  bit         stall     = 1'b0;
  bit         no_busy   = 1'b0;
  int         busy_len  = 4;
  int         last_fall = -1000;
  int         exec_in_rsp = 0;
  int         exec_double = 0;
  bit         m_active  = 1'b0;
  int         m_cnt     = 0;
  bit         prev_exec = 1'b0;
  bit         prev_rv   = 1'b0;
  exec_t      exec_q[$];
  logic [7:0] rsp_data_q[$];
  logic [7:0] rsp_reg_q[$];
  cmd_t       exp_q[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Downstream controller: busy for busy_len cycles per execute, read data = reg ^ 0x5B.
  initial begin
    ctl_busy_i = 1'b0;
    ctl_data_i = 8'h00;
    forever begin
      @(negedge clk);
      if (ctl_execute_o) begin
        exec_q.push_back('{c: cmd_t'({ctl_address_o, ctl_rw_o, ctl_register_o, ctl_data_o}),
                           cyc: cyc, fall: last_fall});
        if (rsp_valid_o) exec_in_rsp++;
        if (prev_exec)   exec_double++;
        if (!no_busy && !m_active) begin
          m_active   = 1'b1;
          m_cnt      = busy_len;
          ctl_data_i = ctl_register_o ^ 8'h5B;
        end
      end else if (m_active) begin
        if (m_cnt > 1) m_cnt--;
        else begin
          m_active  = 1'b0;
          last_fall = cyc;
        end
      end
      if (rsp_valid_o && !prev_rv) begin
        rsp_data_q.push_back(rsp_data_o);
        rsp_reg_q.push_back(rsp_reg_o);
      end
      prev_exec  = ctl_execute_o;
      prev_rv    = rsp_valid_o;
      ctl_busy_i = m_active || stall;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic cmd_t rand_cmd();
    logic [31:0] r;
    r = $urandom;
    return r[23:0];
  endfunction

  task automatic push_wait(input cmd_t c);
    int budget = 200;
    cmd_addr_i  = c.addr;
    cmd_rw_i    = c.rw;
    cmd_reg_i   = c.rg;
    cmd_data_i  = c.data;
    cmd_valid_i = 1'b1;
    while (!cmd_ready_o && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("push_accept", 32'(cmd_ready_o), 32'd1);
    if (cmd_ready_o) exp_q.push_back(c);
    @(negedge clk);
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_execs(input int n, input int budget);
    while (exec_q.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("exec_arrival", 32'(exec_q.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    while (!idle_o && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("idle_reached", 32'(idle_o), 32'd1);
  endtask

  // Compare issued commands and responses against the reference queue, then clear.
  task automatic verify(input string tag);
    int k = 0;
    check({tag, "_n_exec"}, 32'(exec_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < exec_q.size()) check({tag, "_exec_fields"}, 32'(exec_q[i].c), 32'(exp_q[i]));
      if (exp_q[i].rw) begin
        if (k < rsp_data_q.size()) begin
          check({tag, "_rsp_reg"},  32'(rsp_reg_q[k]),  32'(exp_q[i].rg));
          check({tag, "_rsp_data"}, 32'(rsp_data_q[k]), 32'(exp_q[i].rg ^ 8'h5B));
        end
        k++;
      end
    end
    check({tag, "_n_rsp"}, 32'(rsp_data_q.size()), 32'(k));
    exec_q.delete();
    exp_q.delete();
    rsp_data_q.delete();
    rsp_reg_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready_o),    32'd1);
    check({tag, "_idle"},      32'(idle_o),         32'd1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid_o),    32'd0);
    check({tag, "_err"},       32'(err_o),          32'd0);
    check({tag, "_execute"},   32'(ctl_execute_o),  32'd0);
    check({tag, "_ctl_addr"},  32'(ctl_address_o),  32'd0);
    check({tag, "_ctl_rw"},    32'(ctl_rw_o),       32'd0);
    check({tag, "_ctl_reg"},   32'(ctl_register_o), 32'd0);
    check({tag, "_ctl_data"},  32'(ctl_data_o),     32'd0);
    check({tag, "_rsp_data"},  32'(rsp_data_o),     32'd0);
    check({tag, "_rsp_reg"},   32'(rsp_reg_o),      32'd0);
  endtask

  initial begin
    cmd_t c;
    int   d, n0, e, budget;

    rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_rw_i = 1'b0;
    cmd_addr_i = '0; cmd_reg_i = '0; cmd_data_i = '0; rsp_ready_i = 1'b0;
    tick(3);
    check_reset_values("reset");
    rst_i = 1'b0;
    tick(2);

    // Single write: one execute, no response, idle once the gap has elapsed
    busy_len = 100;
    push_wait(cmd_t'({7'h40, 1'b0, 8'h06, 8'h55}));
    wait_execs(1, 20);
    wait_idle(300);
    d = cyc - last_fall;
    check("write_idle_after_gap", 32'(d >= GAP_TICKS + 1 && d <= GAP_TICKS + 3), 32'd1);
    verify("write");

    // Read with a held-off consumer
    busy_len = 6;
    rsp_ready_i = 1'b0;
    push_wait(cmd_t'({7'h40, 1'b1, 8'hFE, 8'h00}));
    budget = 100;
    while (!rsp_valid_o && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    n0 = exec_q.size();
    for (int i = 0; i < 10; i++) begin
      check("read_hold_valid", 32'(rsp_valid_o), 32'd1);
      check("read_hold_data",  32'(rsp_data_o),  32'h A5);
      check("read_hold_reg",   32'(rsp_reg_o),   32'h FE);
      tick(1);
    end
    check("read_no_exec_in_hold", 32'(exec_q.size()), 32'(n0));
    rsp_ready_i = 1'b1;
    tick(1);
    check("read_valid_drops", 32'(rsp_valid_o), 32'd0);
    rsp_ready_i = 1'b0;
    wait_idle(100);
    verify("read");

    // Back-to-back writes are spaced by the gap
    busy_len = 4;
    c = rand_cmd(); c.rw = 1'b0; push_wait(c);
    c = rand_cmd(); c.rw = 1'b0; push_wait(c);
    wait_execs(2, 200);
    if (exec_q.size() >= 2) begin
      d = exec_q[1].cyc - exec_q[1].fall;
      check("b2b_gap_spacing", 32'(d >= GAP_TICKS + 1), 32'd1);
    end
    wait_idle(200);
    verify("b2b");

    // FIFO fill while the controller is stalled busy
    stall = 1'b1;
    rsp_ready_i = 1'b1;
    tick(2);
    for (int i = 0; i <= DEPTH; i++) begin
      c = rand_cmd();
      cmd_addr_i = c.addr; cmd_rw_i = c.rw; cmd_reg_i = c.rg; cmd_data_i = c.data;
      cmd_valid_i = 1'b1;
      check("fill_ready", 32'(cmd_ready_o), 32'(exp_q.size() < DEPTH));
      if (exp_q.size() < DEPTH) exp_q.push_back(c);
      tick(1);
      cmd_valid_i = 1'b0;
    end
    check("fill_no_exec_while_busy", 32'(exec_q.size()), 32'd0);
    stall = 1'b0;
    wait_execs(DEPTH, DEPTH * 100);
    wait_idle(300);
    verify("fill");

    // Random traffic
    for (int i = 0; i < 8; i++) begin
      busy_len = $urandom_range(1, 10);
      push_wait(rand_cmd());
      tick($urandom_range(0, 40));
    end
    wait_execs(8, 2000);
    wait_idle(1000);
    verify("random");

    // Busy timeout: sticky error, next command still issues
    no_busy = 1'b1;
    c = rand_cmd(); c.rw = 1'b0; push_wait(c);
    c = rand_cmd(); c.rw = 1'b1; push_wait(c);
    wait_execs(1, 50);
    e = (exec_q.size() > 0) ? exec_q[0].cyc : cyc;
    budget = 40;
    while (!err_o && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    d = cyc - e;
    check("tmo_err_set", 32'(err_o), 32'd1);
    check("tmo_err_delay", 32'(d >= BUSY_TIMEOUT && d <= BUSY_TIMEOUT + 2), 32'd1);
    no_busy = 1'b0;
    wait_execs(2, 200);
    check("tmo_err_sticky", 32'(err_o), 32'd1);
    wait_idle(200);
    check("tmo_err_sticky_idle", 32'(err_o), 32'd1);
    verify("tmo");

    // Reset in WAIT_DONE with two commands queued
    busy_len = 60;
    for (int i = 0; i < 3; i++) push_wait(rand_cmd());
    wait_execs(1, 20);
    tick(5);
    check("mid_not_idle", 32'(idle_o), 32'd0);
    rst_i = 1'b1;
    stall = 1'b1;
    tick(1);
    check_reset_values("mid_reset");
    rst_i = 1'b0;
    n0 = exec_q.size();
    tick(20);
    check("mid_no_exec_while_busy", 32'(exec_q.size()), 32'(n0));
    stall = 1'b0;
    tick(100);
    check("mid_queue_discarded", 32'(exec_q.size()), 32'(n0));
    check("mid_idle_after", 32'(idle_o), 32'd1);
    check("mid_no_rsp", 32'(rsp_data_q.size()), 32'd0);

    check("exec_during_rsp", 32'(exec_in_rsp), 32'd0);
    check("exec_multi_cycle", 32'(exec_double), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
